// File: rtl/neuron_learn_layer_seq.sv
// Time-multiplexed learning layer: M neurons x N inputs share one MAC, with an
// optional delta-rule pass and valid/ready handshakes on both sides.
// state | meaning
// IDLE  | waiting for an input bundle (in_ready=1)
// FWD   | forward MACs, j outer / i inner, M*N cycles
// LRN   | weight update and back accumulation, M*N cycles
// FIN   | produce expected_in (only if learning ran)
// HOLD  | result valid, waiting for out_ready
module neuron_learn_layer_seq #(
    parameter int N = 16,
    parameter int M = 38,
    parameter int LR_SHIFT = 2,
    parameter logic signed [15:0] INIT_W = 16'sh4000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              learn,
    input  logic [N*16-1:0]   in,
    input  logic [M*16-1:0]   expected_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [M*16-1:0]   out,
    output logic [N*16-1:0]   expected_in,
    output logic [M*N*16-1:0] weights
);
    localparam int AW = 33 + $clog2(N) + 1;
    localparam int BW = 33 + $clog2(M) + 1;
    localparam int JW = (M > 1) ? $clog2(M) : 1;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_FWD  = 3'd1;
    localparam logic [2:0] S_LRN  = 3'd2;
    localparam logic [2:0] S_FIN  = 3'd3;
    localparam logic [2:0] S_HOLD = 3'd4;

    logic [2:0]        state;
    logic [JW-1:0]     j;
    logic [IW-1:0]     i;
    logic signed [AW-1:0] acc;
    logic [N*BW-1:0]   back;
    logic [N*16-1:0]   in_q;
    logic [M*16-1:0]   tgt_q;
    logic              learn_q;

    logic [15:0]          x_cur, t_cur, y_cur, y_new;
    logic signed [15:0]   w_cur, w_new;
    logic signed [32:0]   fwd_prod, bp_prod;
    logic signed [AW-1:0] acc_next, acc_sh;
    logic signed [16:0]   err;
    logic signed [33:0]   dw_prod;
    logic signed [17:0]   dw, w_sum;
    logic signed [BW-1:0] back_cur, back_next, bk;
    logic signed [63:0]   q, s;
    logic [N*16-1:0]      ein_new;
    logic                 last_i, last_j;

    assign in_ready = (state == S_IDLE);
    assign last_i   = (i == IW'(N - 1));
    assign last_j   = (j == JW'(M - 1));

    always_comb begin
        x_cur    = in_q[int'(i)*16 +: 16];
        t_cur    = tgt_q[int'(j)*16 +: 16];
        y_cur    = out[int'(j)*16 +: 16];
        w_cur    = $signed(weights[(int'(j)*N + int'(i))*16 +: 16]);
        back_cur = $signed(back[int'(i)*BW +: BW]);

        fwd_prod = $signed({1'b0, x_cur}) * w_cur;
        acc_next = acc + AW'(fwd_prod);
        acc_sh   = acc_next >>> 15;
        if (acc_sh[AW-1])
            y_new = '0;
        else if (|acc_sh[AW-2:16])
            y_new = 16'hFFFF;
        else
            y_new = acc_sh[15:0];

        err     = $signed({1'b0, t_cur}) - $signed({1'b0, y_cur});
        dw_prod = err * $signed({1'b0, x_cur});
        dw      = 18'(dw_prod >>> (17 + LR_SHIFT));
        w_sum   = dw + 18'(w_cur);
        if (w_sum > 18'sd32767)
            w_new = 16'sh7FFF;
        else if (w_sum < -18'sd32768)
            w_new = 16'sh8000;
        else
            w_new = w_sum[15:0];

        // back-propagation always uses the weight before this cycle's update
        bp_prod   = w_cur * err;
        back_next = back_cur + BW'(bp_prod);
    end

    always_comb begin
        ein_new = expected_in;
        bk = '0;
        q  = '0;
        s  = '0;
        for (int k = 0; k < N; k++) begin
            bk = $signed(back[k*BW +: BW]);
            q  = (64'(bk) >>> 15) / 64'(M);
            s  = q + $signed({48'b0, in_q[k*16 +: 16]});
            if (s[63])
                ein_new[k*16 +: 16] = '0;
            else if (|s[62:16])
                ein_new[k*16 +: 16] = 16'hFFFF;
            else
                ein_new[k*16 +: 16] = s[15:0];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            out_valid   <= 1'b0;
            out         <= '0;
            expected_in <= '0;
            weights     <= {(M*N){INIT_W}};
            acc         <= '0;
            back        <= '0;
            i           <= '0;
            j           <= '0;
            in_q        <= '0;
            tgt_q       <= '0;
            learn_q     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        in_q    <= in;
                        tgt_q   <= expected_out;
                        learn_q <= learn;
                        i       <= '0;
                        j       <= '0;
                        acc     <= '0;
                        back    <= '0;
                        state   <= S_FWD;
                    end
                end
                S_FWD, S_LRN: begin
                    if (state == S_FWD) begin
                        acc <= acc_next;
                        if (last_i) begin
                            out[int'(j)*16 +: 16] <= y_new;
                            acc <= '0;
                        end
                    end else begin
                        back[int'(i)*BW +: BW] <= back_next;
                        weights[(int'(j)*N + int'(i))*16 +: 16] <= w_new;
                    end
                    if (last_i) begin
                        i <= '0;
                        if (last_j) begin
                            j <= '0;
                            state <= (state == S_FWD && learn_q) ? S_LRN : S_FIN;
                        end else begin
                            j <= j + JW'(1);
                        end
                    end else begin
                        i <= i + IW'(1);
                    end
                end
                S_FIN: begin
                    if (learn_q)
                        expected_in <= ein_new;
                    out_valid <= 1'b1;
                    state     <= S_HOLD;
                end
                S_HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_neuron_learn_layer_seq.sv
// Directed bench: three parameterisations (4x2 nominal, 4x2 saturating, 1x1)
// with hand-computed outputs, weights, expected_in and latency.
module tb_neuron_learn_layer_seq;
    logic clock = 1'b0;
    logic rst = 1'b1;
    always #5 clock = ~clock;

    logic a_in_valid, a_in_ready, a_learn, a_out_valid, a_out_ready;
    logic [63:0] a_in, a_ein;
    logic [31:0] a_exp, a_out;
    logic [127:0] a_w;
    logic b_in_valid, b_in_ready, b_learn, b_out_valid, b_out_ready;
    logic [63:0] b_in, b_ein;
    logic [31:0] b_exp, b_out;
    logic [127:0] b_w;
    logic c_in_valid, c_in_ready, c_learn, c_out_valid, c_out_ready;
    logic [15:0] c_in, c_ein, c_exp, c_out, c_w;

    neuron_learn_layer_seq #(.N(4), .M(2), .LR_SHIFT(2), .INIT_W(16'sh4000)) u_a (
        .clock(clock), .reset(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .learn(a_learn), .in(a_in), .expected_out(a_exp), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .out(a_out), .expected_in(a_ein), .weights(a_w));

    neuron_learn_layer_seq #(.N(4), .M(2), .LR_SHIFT(2), .INIT_W(16'sh7FFF)) u_b (
        .clock(clock), .reset(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .learn(b_learn), .in(b_in), .expected_out(b_exp), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .out(b_out), .expected_in(b_ein), .weights(b_w));

    neuron_learn_layer_seq #(.N(1), .M(1), .LR_SHIFT(2), .INIT_W(16'sh8000)) u_c (
        .clock(clock), .reset(rst), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .learn(c_learn), .in(c_in), .expected_out(c_exp), .out_valid(c_out_valid),
        .out_ready(c_out_ready), .out(c_out), .expected_in(c_ein), .weights(c_w));

    int checks = 0;
    int errors = 0;
    int lat;

    typedef struct {
        logic        lrn;
        logic [15:0] xv;
        logic [15:0] tv;
        logic [15:0] yo;
        logic [15:0] wv;
        logic [15:0] ei;
        int          lat;
    } vec_t;
    vec_t vt[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic check_w(input string name, input logic [127:0] w, input int cnt, input logic [15:0] e);
        for (int k = 0; k < cnt; k++)
            check($sformatf("%s[%0d]", name, k), 64'(w[k*16 +: 16]), 64'(e));
    endtask

    function automatic logic get_valid(input int k);
        case (k)
            0: return a_out_valid;
            1: return b_out_valid;
            default: return c_out_valid;
        endcase
    endfunction

    // accept edge counts as cycle 1; returns the cycle on which out_valid is seen
    task automatic wait_out(input int k, output int l);
        l = 1;
        @(posedge clock); #1;
        case (k)
            0: a_in_valid = 1'b0;
            1: b_in_valid = 1'b0;
            default: c_in_valid = 1'b0;
        endcase
        while (!get_valid(k) && l < 200) begin
            @(posedge clock); #1;
            l++;
        end
    endtask

    task automatic release_out(input int k);
        case (k)
            0: a_out_ready = 1'b1;
            1: b_out_ready = 1'b1;
            default: c_out_ready = 1'b1;
        endcase
        @(posedge clock); #1;
        a_out_ready = 1'b0;
        b_out_ready = 1'b0;
        c_out_ready = 1'b0;
        check($sformatf("release_valid_%0d", k), 64'(get_valid(k)), 64'd0);
    endtask

    initial begin
        a_in_valid = 0; a_learn = 0; a_in = '0; a_exp = '0; a_out_ready = 0;
        b_in_valid = 0; b_learn = 0; b_in = '0; b_exp = '0; b_out_ready = 0;
        c_in_valid = 0; c_learn = 0; c_in = '0; c_exp = '0; c_out_ready = 0;

        vt[0] = '{1'b0, 16'h4000, 16'h0000, 16'h8000, 16'h4000, 16'h0000, 10};
        vt[1] = '{1'b1, 16'h4000, 16'hC000, 16'h8000, 16'h4200, 16'h6000, 18};
        vt[2] = '{1'b0, 16'h4000, 16'h0000, 16'h8400, 16'h4200, 16'h6000, 10};
        vt[3] = '{1'b1, 16'h4000, 16'h8400, 16'h8400, 16'h4200, 16'h4000, 18};
        vt[4] = '{1'b1, 16'h2000, 16'h0000, 16'h4200, 16'h40F8, 16'h0000, 18};

        repeat (2) @(posedge clock);
        #1;
        check("rst_in_ready", 64'(a_in_ready), 64'd1);
        check("rst_out_valid", 64'(a_out_valid), 64'd0);
        check("rst_out", 64'(a_out), 64'd0);
        check("rst_ein", a_ein, 64'd0);
        check_w("rst_wa", a_w, 8, 16'h4000);
        check_w("rst_wb", b_w, 8, 16'h7FFF);
        check("rst_wc", 64'(c_w), 64'h8000);
        rst = 1'b0;
        @(posedge clock); #1;

        // saturating instance: weight 0 would overflow past 0x7FFF without clamping
        b_learn = 1; b_in = {16'h0, 16'h0, 16'h0, 16'h2000}; b_exp = {2{16'hFFFF}}; b_in_valid = 1;
        wait_out(1, lat);
        check("b1_lat", 64'(lat), 64'd18);
        check("b1_out", 64'(b_out), {32'd0, {2{16'h1FFF}}});
        check_w("b1_w", b_w, 8, 16'h7FFF);
        check("b1_ein", b_ein, {16'hDFFE, 16'hDFFE, 16'hDFFE, 16'hFFFE});
        release_out(1);
        b_in = {4{16'hFFFF}}; b_in_valid = 1;
        wait_out(1, lat);
        check("b2_lat", 64'(lat), 64'd18);
        check("b2_out", 64'(b_out), {32'd0, {2{16'hFFFF}}});
        check_w("b2_w", b_w, 8, 16'h7FFF);
        check("b2_ein", b_ein, {4{16'hFFFF}});
        release_out(1);

        // 1x1 instance with weight -1.0
        c_learn = 0; c_in = 16'hFFFF; c_exp = 16'h0000; c_in_valid = 1;
        wait_out(2, lat);
        check("c1_lat", 64'(lat), 64'd3);
        check("c1_out", 64'(c_out), 64'd0);
        check("c1_w", 64'(c_w), 64'h8000);
        check("c1_ein", 64'(c_ein), 64'd0);
        release_out(2);
        c_learn = 1; c_exp = 16'h8000; c_in_valid = 1;
        wait_out(2, lat);
        check("c2_lat", 64'(lat), 64'd4);
        check("c2_out", 64'(c_out), 64'd0);
        check("c2_w", 64'(c_w), 64'h8FFF);
        check("c2_ein", 64'(c_ein), 64'h7FFF);
        release_out(2);

        for (int v = 0; v < 5; v++) begin
            a_learn = vt[v].lrn; a_in = {4{vt[v].xv}}; a_exp = {2{vt[v].tv}};
            check($sformatf("v%0d_in_ready", v), 64'(a_in_ready), 64'd1);
            a_in_valid = 1;
            wait_out(0, lat);
            check($sformatf("v%0d_lat", v), 64'(lat), 64'(vt[v].lat));
            check($sformatf("v%0d_out", v), 64'(a_out), 64'({2{vt[v].yo}}));
            check($sformatf("v%0d_ein", v), a_ein, {4{vt[v].ei}});
            check_w($sformatf("v%0d_w", v), a_w, 8, vt[v].wv);
            release_out(0);
        end

        // back-pressure: result must stay put and new bundles be refused
        a_learn = 0; a_in = {4{16'h4000}}; a_exp = '0; a_in_valid = 1;
        wait_out(0, lat);
        check("hold_lat", 64'(lat), 64'd10);
        for (int c = 0; c < 20; c++) begin
            a_in_valid = (c == 3 || c == 4);
            a_in = {4{16'h1000}};
            @(posedge clock); #1;
            check($sformatf("hold_out_%0d", c), 64'(a_out), 64'({2{16'h81F0}}));
            check($sformatf("hold_valid_%0d", c), 64'(a_out_valid), 64'd1);
            check($sformatf("hold_in_ready_%0d", c), 64'(a_in_ready), 64'd0);
        end
        a_in_valid = 1; a_out_ready = 1;
        @(posedge clock); #1;
        a_out_ready = 0;
        check("hs_out_valid", 64'(a_out_valid), 64'd0);
        check("hs_in_ready", 64'(a_in_ready), 64'd1);
        wait_out(0, lat);
        check("second_lat", 64'(lat), 64'd10);
        check("second_out", 64'(a_out), 64'({2{16'h207C}}));
        release_out(0);

        a_out_ready = 1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clock); #1;
            check($sformatf("idle_ready_valid_%0d", c), 64'(a_out_valid), 64'd0);
            check($sformatf("idle_ready_out_%0d", c), 64'(a_out), 64'({2{16'h207C}}));
        end
        a_out_ready = 0;

        // reset five cycles into the learning pass
        a_learn = 1; a_in = {4{16'h4000}}; a_exp = {2{16'hC000}}; a_in_valid = 1;
        @(posedge clock); #1;
        a_in_valid = 0;
        repeat (13) @(posedge clock);
        #1 rst = 1'b1;
        #1;
        check_w("mid_rst_w", a_w, 8, 16'h4000);
        check("mid_rst_in_ready", 64'(a_in_ready), 64'd1);
        check("mid_rst_out_valid", 64'(a_out_valid), 64'd0);
        check("mid_rst_out", 64'(a_out), 64'd0);
        check("mid_rst_ein", a_ein, 64'd0);
        #2 rst = 1'b0;
        @(posedge clock); #1;
        a_learn = 0; a_in = {4{16'h4000}}; a_exp = '0; a_in_valid = 1;
        wait_out(0, lat);
        check("after_rst_lat", 64'(lat), 64'd10);
        check("after_rst_out", 64'(a_out), 64'({2{16'h8000}}));
        check_w("after_rst_w", a_w, 8, 16'h4000);
        release_out(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
